cond_logic: RTL and testbench
=============================

Name: cond_logic

Overview:
- Conditional-execution stage directly downstream of the ALU decoder in the single-cycle ARM control unit.
- Holds the architectural NZCV flag register and updates it under the decoder's FlagW enables.
- Evaluates the instruction's 4-bit condition field against the current flags, and gates PCS/RegW/MemW into the final PCSrc/RegWrite/MemWrite strobes.
- Keeps saturating executed/squashed instruction counters for debug.

Parameters:
CNT_W, 32, width of the ExecCount and SquashCount counters (min 4).

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
Valid  input  1  current instruction is real (0 = bubble/stall: no writes, no flag update, no count)
Cond  input  4  instruction condition field, Instr[31:28]
ALUFlags  input  4  {N,Z,C,V} from the ALU for the current instruction
FlagW  input  2  from decoder; [1] enables NZ write, [0] enables CV write
NoWrite  input  1  from decoder; suppresses register write (CMP)
PCS  input  1  PC-write request (branch or write to R15)
RegW  input  1  register-write request from main decoder
MemW  input  1  memory-write request from main decoder
CntClr  input  1  synchronous clear of both counters
PCSrc  output  1  PCS & CondEx & Valid
RegWrite  output  1  RegW & CondEx & ~NoWrite & Valid
MemWrite  output  1  MemW & CondEx & Valid
CondEx  output  1  condition passed for the current instruction, from the registered flags
Flags  output  4  registered {N,Z,C,V}
ExecCount  output  CNT_W  count of valid instructions with CondEx=1
SquashCount  output  CNT_W  count of valid instructions with CondEx=0

Behaviour:
- Reset (sync, on a clk edge with reset=1): Flags=4'b0000, ExecCount=0, SquashCount=0. Reset overrides every other input in that cycle.
- Combinational outputs follow their equations with no reset value of their own. After reset, with Flags=0: EQ gives CondEx=0 and AL gives CondEx=1.
- CondEx always uses the registered Flags, never ALUFlags. An instruction's own flag result is invisible to its own condition check.
- Condition table, with Flags = {N,Z,C,V}:
  - 0000 EQ Z; 0001 NE ~Z
  - 0010 CS C; 0011 CC ~C
  - 0100 MI N; 0101 PL ~N
  - 0110 VS V; 0111 VC ~V
  - 1000 HI C&~Z; 1001 LS ~C|Z
  - 1010 GE N==V; 1011 LT N!=V
  - 1100 GT ~Z&(N==V); 1101 LE Z|(N!=V)
  - 1110 AL 1
  - 1111 is unsupported: CondEx=0 (squash).
- Flag update (registered, 1-cycle latency): FlagWrite = FlagW & {2{CondEx & Valid}}.
  - FlagWrite[1]: Flags[3:2] <= ALUFlags[3:2].
  - FlagWrite[0]: Flags[1:0] <= ALUFlags[1:0].
  - Each half is independent; an un-enabled half holds its value.
  - New flags are visible to the next instruction's CondEx.
- A squashed CMP (CondEx=0) writes no flags. NoWrite has no effect on flag update.
- Counters, evaluated per edge in this priority order:
  1. reset
  2. CntClr: both counters <= 0, and the current instruction is not counted
  3. Valid & CondEx: ExecCount += 1
  4. Valid & ~CondEx: SquashCount += 1
- Each counter saturates at all-ones and holds there; it never wraps.
- Valid=0: PCSrc=RegWrite=MemWrite=0, Flags hold, counters hold (CntClr still clears). CondEx is still driven from the registered flags.
- No state machine beyond the flag and counter registers. Single-cycle throughput: one instruction evaluated per clock.

Decomposition:
- Shared package arm_ctrl_pkg:
  - cond_e enum (EQ…AL, NV=4'hF)
  - flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0
  - FLAGW_NZ=1, FLAGW_CV=0
- One natural sub-module: cond_check. It is purely combinational: Cond and Flags in, CondEx out, implementing the table above. It is instantiated once.
- Flag register, gating and counters stay in cond_logic.

Test Plan:
1. Reset, then Cond=0000 (EQ), RegW=1, Valid=1 -> Flags=0000, CondEx=0, RegWrite=0, SquashCount=1 after the edge.
2. CMP: FlagW=11, NoWrite=1, Cond=1110, ALUFlags=0110 -> RegWrite=0 this cycle, Flags=0110 after the edge. Next cycle Cond=0000 -> CondEx=1. Cond=1000 (HI) -> CondEx=0.
3. Flags=0000, then FlagW=10 with ALUFlags=1111, AL -> Flags=1100 (CV untouched). Then FlagW=01 with ALUFlags=0001 -> Flags=1101.
4. Same-cycle independence: Flags=0000, Cond=0001 (NE), FlagW=11, ALUFlags=0100 -> CondEx=1 from the old flags, Flags=0100 after the edge. Next NE -> CondEx=0. A squashed FlagW=11 instruction leaves Flags unchanged.
5. Sweep all 16 Cond values against all 16 Flags values -> CondEx matches the table exactly. 1111 always gives 0. PCSrc/MemWrite follow PCS/MemW & CondEx.
6. CNT_W=4: 20 executed instructions -> ExecCount saturates at 15. CntClr with Valid&CondEx in the same cycle -> both counters 0. Valid=0 with RegW=1, FlagW=11 -> no writes, Flags and counters hold.

Source files
------------

// File: rtl/arm_ctrl_pkg.sv
// Shared definitions for the ARM control unit: condition mnemonics,
// flag bit positions inside {N,Z,C,V} and the FlagW enable bit positions.
package arm_ctrl_pkg;

  typedef enum logic [3:0] {
    EQ = 4'h0,
    NE = 4'h1,
    CS = 4'h2,
    CC = 4'h3,
    MI = 4'h4,
    PL = 4'h5,
    VS = 4'h6,
    VC = 4'h7,
    HI = 4'h8,
    LS = 4'h9,
    GE = 4'hA,
    LT = 4'hB,
    GT = 4'hC,
    LE = 4'hD,
    AL = 4'hE,
    NV = 4'hF
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int FLAGW_NZ = 1;
  localparam int FLAGW_CV = 0;

endpackage

// File: rtl/cond_check.sv
// Condition evaluator: decides whether an instruction executes, given its
// 4-bit condition field and the architectural flags. Purely combinational.
module cond_check
  import arm_ctrl_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondEx
);

  logic n;
  logic z;
  logic c;
  logic v;

  assign n = Flags[FLAG_N];
  assign z = Flags[FLAG_Z];
  assign c = Flags[FLAG_C];
  assign v = Flags[FLAG_V];

  // Condition table; NV (1111) is not supported and always squashes
  always_comb begin
    CondEx = 1'b0;
    case (Cond)
      EQ:      CondEx = z;
      NE:      CondEx = ~z;
      CS:      CondEx = c;
      CC:      CondEx = ~c;
      MI:      CondEx = n;
      PL:      CondEx = ~n;
      VS:      CondEx = v;
      VC:      CondEx = ~v;
      HI:      CondEx = c & ~z;
      LS:      CondEx = ~c | z;
      GE:      CondEx = (n == v);
      LT:      CondEx = (n != v);
      GT:      CondEx = ~z & (n == v);
      LE:      CondEx = z | (n != v);
      AL:      CondEx = 1'b1;
      default: CondEx = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_logic.sv
// Conditional-execution stage of the single-cycle ARM control unit.
// Holds NZCV, gates the decoder's write requests with the condition result
// and keeps saturating executed/squashed instruction counters for debug.
module cond_logic
  import arm_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Valid,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             NoWrite,
  input  logic             PCS,
  input  logic             RegW,
  input  logic             MemW,
  input  logic             CntClr,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             CondEx,
  output logic [3:0]       Flags,
  output logic [CNT_W-1:0] ExecCount,
  output logic [CNT_W-1:0] SquashCount
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [3:0]       flags_q;
  logic             cond_ex;
  logic             go;
  logic [1:0]       flag_write;
  logic [CNT_W-1:0] exec_q;
  logic [CNT_W-1:0] squash_q;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (&x) ? x : (x + CNT_ONE);
  endfunction

  // The condition is judged on the flags as they stood before this
  // instruction, so its own ALU result cannot influence it.
  cond_check u_cond_check (
    .Cond   (Cond),
    .Flags  (flags_q),
    .CondEx (cond_ex)
  );

  assign go         = cond_ex & Valid;
  assign flag_write = FlagW & {2{go}};

  assign CondEx   = cond_ex;
  assign PCSrc    = PCS & go;
  assign RegWrite = RegW & go & ~NoWrite;
  assign MemWrite = MemW & go;
  assign Flags    = flags_q;

  // Flag register: NZ and CV halves are written independently
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= 4'b0000;
    end else begin
      if (flag_write[FLAGW_NZ]) flags_q[FLAG_N:FLAG_Z] <= ALUFlags[FLAG_N:FLAG_Z];
      if (flag_write[FLAGW_CV]) flags_q[FLAG_C:FLAG_V] <= ALUFlags[FLAG_C:FLAG_V];
    end
  end

  // Debug counters: a clear wins over counting the current instruction
  always_ff @(posedge clk) begin
    if (reset || CntClr) begin
      exec_q   <= '0;
      squash_q <= '0;
    end else if (Valid) begin
      if (cond_ex) exec_q   <= sat_inc(exec_q);
      else         squash_q <= sat_inc(squash_q);
    end
  end

  assign ExecCount   = exec_q;
  assign SquashCount = squash_q;

endmodule

// File: tb/tb_cond_logic.sv
// Bench for cond_logic with 4-bit counters so saturation is reachable.
module tb_cond_logic;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             Valid;
  logic [3:0]       Cond;
  logic [3:0]       ALUFlags;
  logic [1:0]       FlagW;
  logic             NoWrite;
  logic             PCS;
  logic             RegW;
  logic             MemW;
  logic             CntClr;
  logic             PCSrc;
  logic             RegWrite;
  logic             MemWrite;
  logic             CondEx;
  logic [3:0]       Flags;
  logic [CNT_W-1:0] ExecCount;
  logic [CNT_W-1:0] SquashCount;

  cond_logic #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .Valid       (Valid),
    .Cond        (Cond),
    .ALUFlags    (ALUFlags),
    .FlagW       (FlagW),
    .NoWrite     (NoWrite),
    .PCS         (PCS),
    .RegW        (RegW),
    .MemW        (MemW),
    .CntClr      (CntClr),
    .PCSrc       (PCSrc),
    .RegWrite    (RegWrite),
    .MemWrite    (MemWrite),
    .CondEx      (CondEx),
    .Flags       (Flags),
    .ExecCount   (ExecCount),
    .SquashCount (SquashCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic [3:0] cond;
    logic [3:0] alu;
    logic [1:0] fw;
    logic       nw;
    logic       pcs;
    logic       regw;
    logic       memw;
    logic       clr;
    logic       exp_ce;
    logic       exp_rw;
    logic [3:0] exp_flags;
  } vec_t;

  int total = 0;
  int bad   = 0;

  // Reference state
  logic [3:0] m_flags;
  int         m_exec;
  int         m_squash;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Condition rule: pairs of codes share a predicate, odd code inverts it
  function automatic bit model_cond(input logic [3:0] cond, input logic [3:0] f);
    bit n, z, c, v, base;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    if (cond == 4'hF) return 1'b0;
    if (cond == 4'hE) return 1'b1;
    case (cond[3:1])
      3'd0:    base = z;
      3'd1:    base = c;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = c && !z;
      3'd5:    base = (n == v);
      3'd6:    base = !z && (n == v);
      default: base = 1'b0;
    endcase
    return cond[0] ? !base : base;
  endfunction

  function automatic vec_t mk(input logic valid, input logic [3:0] cond, input logic [3:0] alu,
                              input logic [1:0] fw, input logic nw, input logic pcs,
                              input logic regw, input logic memw, input logic clr);
    vec_t r;
    r = '{valid, cond, alu, fw, nw, pcs, regw, memw, clr, 1'b0, 1'b0, 4'h0};
    return r;
  endfunction

  function automatic int sat(input int x);
    return (x >= 15) ? 15 : x + 1;
  endfunction

  // One instruction per clock; use_exp selects the hand-written expectations
  task automatic step(input vec_t r, input bit use_exp);
    bit ce;
    @(negedge clk);
    Valid = r.valid; Cond = r.cond; ALUFlags = r.alu; FlagW = r.fw;
    NoWrite = r.nw; PCS = r.pcs; RegW = r.regw; MemW = r.memw; CntClr = r.clr;
    #1;
    ce = model_cond(r.cond, m_flags);
    if (use_exp) begin
      check("tbl_condex", 4'(CondEx), 4'(r.exp_ce));
      check("tbl_regwrite", 4'(RegWrite), 4'(r.exp_rw));
    end else begin
      check("condex", 4'(CondEx), 4'(ce));
      check("regwrite", 4'(RegWrite), 4'(r.regw & ce & !r.nw & r.valid));
    end
    check("pcsrc", 4'(PCSrc), 4'(r.pcs & ce & r.valid));
    check("memwrite", 4'(MemWrite), 4'(r.memw & ce & r.valid));
    @(posedge clk);
    if (r.valid && ce) begin
      if (r.fw[1]) m_flags[3:2] = r.alu[3:2];
      if (r.fw[0]) m_flags[1:0] = r.alu[1:0];
    end
    if (r.clr) begin
      m_exec = 0; m_squash = 0;
    end else if (r.valid) begin
      if (ce) m_exec = sat(m_exec);
      else    m_squash = sat(m_squash);
    end
    #1;
    if (use_exp) check("tbl_flags", Flags, r.exp_flags);
    else         check("flags", Flags, m_flags);
    check("exec_count", ExecCount, 4'(m_exec));
    check("squash_count", SquashCount, 4'(m_squash));
  endtask

  // Reset asserted together with an instruction that would otherwise write
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; Valid = 1'b1; Cond = 4'hE; ALUFlags = 4'hF; FlagW = 2'b11;
    NoWrite = 1'b0; PCS = 1'b1; RegW = 1'b1; MemW = 1'b1; CntClr = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0; Valid = 1'b0;
    m_flags = 4'h0; m_exec = 0; m_squash = 0;
    check("rst_flags", Flags, 4'h0);
    check("rst_exec", ExecCount, 4'h0);
    check("rst_squash", SquashCount, 4'h0);
  endtask

  vec_t tbl[14];

  initial begin
    //          vld  cond   alu    fw     nw   pcs  regw memw clr  ce   rw   flags
    tbl[0]  = '{1'b1, 4'h0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0}; // EQ after reset
    tbl[1]  = '{1'b1, 4'hE, 4'h6, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h6}; // CMP
    tbl[2]  = '{1'b1, 4'h0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'h6}; // EQ sees Z
    tbl[3]  = '{1'b1, 4'h8, 4'h0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h6}; // HI fails
    tbl[4]  = '{1'b1, 4'hE, 4'h0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0}; // clear flags
    tbl[5]  = '{1'b1, 4'hE, 4'hF, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'hC}; // NZ only
    tbl[6]  = '{1'b1, 4'hE, 4'h1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'hD}; // CV only
    tbl[7]  = '{1'b1, 4'hE, 4'h0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0}; // clear flags
    tbl[8]  = '{1'b1, 4'h1, 4'h4, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'h4}; // NE on old flags
    tbl[9]  = '{1'b1, 4'h1, 4'h0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h4}; // NE now fails
    tbl[10] = '{1'b1, 4'h1, 4'hB, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h4}; // squashed FlagW
    tbl[11] = '{1'b1, 4'hF, 4'h0, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h4}; // NV squashed CMP
    tbl[12] = '{1'b0, 4'hE, 4'hA, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'h4}; // bubble
    tbl[13] = '{1'b1, 4'hA, 4'h0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'h4}; // GE: N==V

    reset = 1'b1; Valid = 1'b0; Cond = 4'h0; ALUFlags = 4'h0; FlagW = 2'b00;
    NoWrite = 1'b0; PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; CntClr = 1'b0;
    m_flags = 4'h0; m_exec = 0; m_squash = 0;

    do_reset();
    for (int i = 0; i < 14; i++) step(tbl[i], 1'b1);

    // Full condition sweep against every flag combination
    for (int f = 0; f < 16; f++) begin
      step(mk(1'b1, 4'hE, 4'(f), 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0);
      for (int c = 0; c < 16; c++)
        step(mk(1'b1, 4'(c), 4'($urandom_range(15)), 2'b00, 1'($urandom_range(1)),
                1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b0), 1'b0);
    end

    // Counter saturation and clear priority
    do_reset();
    for (int i = 0; i < 20; i++) step(mk(1'b1, 4'hE, 4'h0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), 1'b0);
    check("sat_exec", ExecCount, 4'hF);
    step(mk(1'b1, 4'hE, 4'h0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1), 1'b0);
    check("clr_exec", ExecCount, 4'h0);
    check("clr_squash", SquashCount, 4'h0);
    step(mk(1'b0, 4'hE, 4'hF, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0), 1'b0);
    check("bubble_flags", Flags, 4'h0);
    for (int i = 0; i < 20; i++) step(mk(1'b1, 4'hF, 4'hF, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), 1'b0);
    check("sat_squash", SquashCount, 4'hF);
    step(mk(1'b0, 4'h0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), 1'b0);
    check("clr_idle_squash", SquashCount, 4'h0);

    // Random instruction stream
    for (int i = 0; i < 400; i++)
      step(mk(1'($urandom_range(9) != 0), 4'($urandom_range(15)), 4'($urandom_range(15)),
              2'($urandom_range(3)), 1'($urandom_range(1)), 1'($urandom_range(1)),
              1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(19) == 0)), 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
